// File: rtl/pc_unit.sv
// Program counter sequencer: IDLE/RUN/HALT control with a writable branch-target table.
// The table read is combinational, so a same-edge write is seen only from the next cycle on.
module pc_unit #(
    parameter int PC_W     = 10,
    parameter int LUT_D    = 32,
    parameter int START_PC = 0,
    localparam int IDX_W   = (LUT_D > 1) ? $clog2(LUT_D) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             branch_en,
    input  logic             taken,
    input  logic [IDX_W-1:0] jump_sel,
    input  logic             halt_req,
    input  logic             lut_we,
    input  logic [IDX_W-1:0] lut_waddr,
    input  logic [PC_W-1:0]  lut_wdata,
    output logic [PC_W-1:0]  pc,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for start, pc parked at START_PC
    // RUN   | executing, pc advances or branches every cycle
    // HALT  | halted, pc frozen until the next start
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] START_V = PC_W'(START_PC);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [PC_W-1:0] lut_q [LUT_D];
    logic [PC_W-1:0] tgt;

    assign tgt = lut_q[jump_sel];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE: begin
                pc_d = START_V;
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // halt wins over a taken branch in the same cycle
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (branch_en && taken) begin
                    pc_d = tgt;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = START_V;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = START_V;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= START_V;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < LUT_D; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (lut_we) begin
                lut_q[lut_waddr] <= lut_wdata;
            end
        end
    end

    assign pc   = pc_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
- REQ-001: Parameter PC_W, default 10, SHALL set the program counter width.
- REQ-002: Parameter LUT_D, default 32, SHALL set the branch-target table depth; index width SHALL be clog2(LUT_D).
- REQ-003: Parameter START_PC, default 0, SHALL set the program entry address.
- REQ-004: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-005: reset  input  1  SHALL be the synchronous, active-high reset.
- REQ-006: start  input  1  SHALL be the program launch request, sampled in IDLE or HALT.
- REQ-007: branch_en  input  1  SHALL indicate the current instruction is a conditional branch.
- REQ-008: taken  input  1  SHALL be the ALU branch-condition result.
- REQ-009: jump_sel  input  clog2(LUT_D)  SHALL be the branch-target table index.
- REQ-010: halt_req  input  1  SHALL indicate the current instruction is halt.
- REQ-011: lut_we  input  1  SHALL be the target-table write enable.
- REQ-012: lut_waddr  input  clog2(LUT_D)  SHALL be the target-table write index.
- REQ-013: lut_wdata  input  PC_W  SHALL be the target-table write data.
- REQ-014: pc  output  PC_W  SHALL be the current instruction address, registered.
- REQ-015: busy  output  1  SHALL be high only in state RUN.
- REQ-016: done  output  1  SHALL be high only in state HALT.

Function
- REQ-017: The FSM SHALL have exactly three states: IDLE, RUN, HALT.
- REQ-018: IDLE: pc SHALL hold START_PC; start=1 -> RUN next cycle, pc stays START_PC for the first RUN cycle.
- REQ-019: RUN, halt_req=1: next state HALT, pc SHALL hold its value.
- REQ-020: RUN, halt_req=0, branch_en=1, taken=1: pc SHALL load table[jump_sel] next cycle.
- REQ-021: RUN, otherwise: pc SHALL increment by 1 modulo 2^PC_W; all-ones wraps to 0 with no flag.
- REQ-022: halt_req SHALL take priority over a simultaneous taken branch.
- REQ-023: taken with branch_en=0 SHALL be ignored; pc increments.
- REQ-024: HALT: pc SHALL hold; start=1 -> RUN with pc reloaded to START_PC next cycle.
- REQ-025: start in RUN SHALL be ignored.
- REQ-026: halt_req, branch_en, taken SHALL be ignored outside RUN.
- REQ-027: Table write SHALL occur on the clock edge when lut_we=1, in any state.
- REQ-028: Table read SHALL be combinational; a same-cycle write/read of one index SHALL return the old entry.
- REQ-029: Branch latency SHALL be one cycle: target appears on pc the cycle after taken is sampled.

Reset
- REQ-030: reset=1 SHALL force state IDLE, pc=START_PC, busy=0, done=0 on the next edge, overriding all other inputs.
- REQ-031: reset SHALL clear every table entry to 0.
- REQ-032: reset asserted mid-RUN or in HALT SHALL abort immediately; no further pc change until a new start.

Verification
- REQ-033: reset, then start pulse, 5 idle cycles -> pc 0,0,1,2,3,4; busy=1, done=0.
- REQ-034: write table[3]=0x155; in RUN at pc=7, branch_en=1, taken=1, jump_sel=3 -> pc=0x155 next cycle; same with taken=0 -> pc=8.
- REQ-035: at pc=0x3FF in RUN, no branch -> pc=0x000 next cycle, busy still 1.
- REQ-036: halt_req=1 with branch_en=1, taken=1 at pc=0x20 -> state HALT, pc=0x20 held, done=1, busy=0; start -> pc=0, busy=1.
- REQ-037: lut_we=1 writing table[5]=0x0AA while branching on jump_sel=5 (old 0x011) -> pc=0x011; repeat -> pc=0x0AA.
- REQ-038: reset at pc=0x040 mid-RUN -> pc=0, IDLE, table[3] reads 0; start ignored during reset cycle.
